// File: rtl/drv_pkg.sv
// Shared types and defaults for the dead-time gate-drive controller.
package drv_pkg;

  localparam int DTW_DEF  = 6;
  localparam int MONW_DEF = 8;
  localparam int SW       = 6;

  // One-hot channel state; the outputs decode from a single bit each.
  typedef enum logic [SW-1:0] {
    S_OFF    = 6'b000001,
    S_DT_TOP = 6'b000010,
    S_TOP_ON = 6'b000100,
    S_DT_BOT = 6'b001000,
    S_BOT_ON = 6'b010000,
    S_FAULT  = 6'b100000
  } drv_state_e;

endpackage

// File: rtl/drv_deadtime_ctrl_if.sv
// Command/config bus between the loop PWM generator and the gate-drive controller.
interface drv_deadtime_ctrl_if #(
  parameter int NCH  = 2,
  parameter int DTW  = drv_pkg::DTW_DEF,
  parameter int MONW = drv_pkg::MONW_DEF
);

  // No valid/ready handshake: pwm/en/config are level signals sampled on every
  // rising edge, fault_clr is a one-cycle pulse, fault_n may change at any time.
  logic [NCH-1:0]               pwm;
  logic [NCH-1:0]               en;
  logic [DTW-1:0]               dt_rise;
  logic [DTW-1:0]               dt_fall;
  logic [MONW-1:0]              min_on;
  logic                         fault_n;
  logic                         fault_clr;
  logic [NCH-1:0]               top;
  logic [NCH-1:0]               bot;
  logic                         fault_flag;
  logic [NCH-1:0][drv_pkg::SW-1:0] dbg_state;

  modport master (
    output pwm, en, dt_rise, dt_fall, min_on, fault_n, fault_clr,
    input  top, bot, fault_flag, dbg_state
  );

  modport slave (
    input  pwm, en, dt_rise, dt_fall, min_on, fault_n, fault_clr,
    output top, bot, fault_flag, dbg_state
  );

endinterface

// File: rtl/drv_deadtime_ch.sv
// One half-bridge channel: Moore FSM with dead-time and minimum top-on counters.
module drv_deadtime_ch
  import drv_pkg::*;
#(
  parameter int DTW  = DTW_DEF,
  parameter int MONW = MONW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwm_i,
  input  logic            en_i,
  input  logic            fault_i,
  input  logic            fault_rel_i,
  input  logic [DTW-1:0]  dt_rise_i,
  input  logic [DTW-1:0]  dt_fall_i,
  input  logic [MONW-1:0] min_on_i,
  output logic            top_o,
  output logic            bot_o,
  output drv_state_e      state_o
);

  localparam logic [DTW-1:0]  DT_ONE  = 1;
  localparam logic [MONW-1:0] MON_ONE = 1;

  drv_state_e      state_q, state_d;
  logic [DTW-1:0]  dt_cnt_q, dt_cnt_d;
  logic [MONW-1:0] mon_q, mon_d;
  logic            top_q, top_d;
  logic            bot_q, bot_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      dt_cnt_q <= '0;
      mon_q    <= '0;
      top_q    <= 1'b0;
      bot_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      mon_q    <= mon_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
    end
  end

  // Counters saturate at zero; a load only happens on entry to a timed phase.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = (dt_cnt_q != '0) ? dt_cnt_q - DT_ONE : '0;
    mon_d    = (mon_q != '0) ? mon_q - MON_ONE : '0;
    if (fault_i) begin
      state_d = S_FAULT;
    end else if (state_q == S_FAULT) begin
      if (fault_rel_i) state_d = S_OFF;
    end else if (!en_i) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          if (pwm_i) begin
            state_d  = S_DT_TOP;
            dt_cnt_d = dt_rise_i;
          end else begin
            state_d  = S_DT_BOT;
            dt_cnt_d = dt_fall_i;
          end
        end
        S_DT_TOP: begin
          if (dt_cnt_q == '0) begin
            state_d = S_TOP_ON;
            mon_d   = min_on_i;
          end
        end
        S_DT_BOT: if (dt_cnt_q == '0) state_d = S_BOT_ON;
        S_TOP_ON: begin
          if (!pwm_i && mon_q == '0) begin
            state_d  = S_DT_BOT;
            dt_cnt_d = dt_fall_i;
          end
        end
        S_BOT_ON: begin
          if (pwm_i) begin
            state_d  = S_DT_TOP;
            dt_cnt_d = dt_rise_i;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Gate enables are flops loaded from the next state, so they never overlap.
  always_comb begin
    top_d = (state_d == S_TOP_ON);
    bot_d = (state_d == S_BOT_ON);
  end

  assign top_o   = top_q;
  assign bot_o   = bot_q;
  assign state_o = state_q;

endmodule

// File: rtl/drv_deadtime_ctrl.sv
// Multi-channel gate-drive controller: shared fault synchroniser/latch plus NCH channels.
module drv_deadtime_ctrl
  import drv_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DTW  = DTW_DEF,
  parameter int MONW = MONW_DEF
) (
  input  logic CELCLK,
  input  logic CELRSTN,
  input  logic CELV,
  input  logic CELG,
  input  logic SUB,
  drv_deadtime_ctrl_if.slave io
);

  // Supply pins only pass through to the generated driver cells.
  logic unused_supply;
  assign unused_supply = CELV ^ CELG ^ SUB;

  logic fmeta_q, fmeta_d;
  logic fsync_q, fsync_d;
  logic fflag_q, fflag_d;
  logic fault_act, fault_rel;

  assign fault_act = ~fsync_q;
  assign fault_rel = io.fault_clr & fsync_q;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      fmeta_q <= 1'b1;
      fsync_q <= 1'b1;
      fflag_q <= 1'b0;
    end else begin
      fmeta_q <= fmeta_d;
      fsync_q <= fsync_d;
      fflag_q <= fflag_d;
    end
  end

  always_comb begin
    fmeta_d = io.fault_n;
    fsync_d = fmeta_q;
    fflag_d = fflag_q;
    if (fault_act)      fflag_d = 1'b1;
    else if (fault_rel) fflag_d = 1'b0;
  end

  assign io.fault_flag = fflag_q;

  logic [NCH-1:0] top_w;
  logic [NCH-1:0] bot_w;
  drv_state_e     st_w [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    drv_deadtime_ch #(
      .DTW  (DTW),
      .MONW (MONW)
    ) u_ch (
      .clk         (CELCLK),
      .rst_n       (CELRSTN),
      .pwm_i       (io.pwm[g]),
      .en_i        (io.en[g]),
      .fault_i     (fault_act),
      .fault_rel_i (fault_rel),
      .dt_rise_i   (io.dt_rise),
      .dt_fall_i   (io.dt_fall),
      .min_on_i    (io.min_on),
      .top_o       (top_w[g]),
      .bot_o       (bot_w[g]),
      .state_o     (st_w[g])
    );
    assign io.dbg_state[g] = st_w[g];
  end

  assign io.top = top_w;
  assign io.bot = bot_w;

endmodule

// File: tb/tb_drv_deadtime_ctrl.sv
// Self-checking bench for drv_deadtime_ctrl: vector table, fault and reset sequences.
module tb_drv_deadtime_ctrl;
  import drv_pkg::*;

  localparam int NCH  = 2;
  localparam int DTW  = 6;
  localparam int MONW = 8;
  localparam int W    = 2 * NCH + 1;
  localparam int NV   = 24;

  typedef struct {
    logic [1:0] pwm;
    logic [1:0] en;
    logic [5:0] dt_rise;
    logic [5:0] dt_fall;
    logic [7:0] min_on;
    int         ncyc;
    logic [1:0] top;
    logic [1:0] bot;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic celv  = 1'b1;
  logic celg  = 1'b0;
  logic sub   = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  vec_t         tbl [NV];

  drv_deadtime_ctrl_if #(.NCH(NCH), .DTW(DTW), .MONW(MONW)) bus ();

  drv_deadtime_ctrl #(.NCH(NCH), .DTW(DTW), .MONW(MONW)) dut (
    .CELCLK  (clk),
    .CELRSTN (rst_n),
    .CELV    (celv),
    .CELG    (celg),
    .SUB     (sub),
    .io      (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] pwm, input logic [1:0] en, input logic [5:0] dtr,
                       input logic [5:0] dtf, input logic [7:0] mon);
    bus.pwm     = pwm;
    bus.en      = en;
    bus.dt_rise = dtr;
    bus.dt_fall = dtf;
    bus.min_on  = mon;
  endtask

  // Called at a falling edge: queue the outputs expected after each of the next n rising edges.
  task automatic run(input string tag, input logic flag, input logic [1:0] t,
                     input logic [1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({flag, t, b});
      tag_q.push_back(tag);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_top"}, 32'(bus.top), 32'd0);
    chk({name, "_bot"}, 32'(bus.bot), 32'd0);
    chk({name, "_flag"}, 32'(bus.fault_flag), 32'd0);
    for (int i = 0; i < NCH; i++)
      chk($sformatf("%s_state%0d", name, i), 32'(bus.dbg_state[i]), 32'(S_OFF));
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    string        tag;
    #1;
    chk("no_overlap", 32'(bus.top & bus.bot), 32'd0);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      got = {bus.fault_flag, bus.top, bus.bot};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got {flag,top,bot}=%b expected %b at %0t", tag, got, exp, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // from reset: dt_fall=3 gives 4 low cycles then bot
    tbl[0]  = '{2'b00, 2'b11, 6'd0, 6'd3, 8'd0,  4, 2'b00, 2'b00};
    tbl[1]  = '{2'b00, 2'b11, 6'd0, 6'd3, 8'd0,  3, 2'b00, 2'b11};
    // ch0 rise with dt_rise=5: bot drops at once, 6 low, top; ch1 stays bot
    tbl[2]  = '{2'b01, 2'b11, 6'd5, 6'd3, 8'd0,  6, 2'b00, 2'b10};
    tbl[3]  = '{2'b01, 2'b11, 6'd5, 6'd3, 8'd0,  3, 2'b01, 2'b10};
    tbl[4]  = '{2'b00, 2'b11, 6'd5, 6'd3, 8'd0,  4, 2'b00, 2'b10};
    tbl[5]  = '{2'b00, 2'b11, 6'd5, 6'd3, 8'd0,  2, 2'b00, 2'b11};
    // 1-cycle pwm pulse with min_on=10: top held 11 cycles
    tbl[6]  = '{2'b01, 2'b11, 6'd2, 6'd3, 8'd10, 1, 2'b00, 2'b10};
    tbl[7]  = '{2'b00, 2'b11, 6'd2, 6'd3, 8'd10, 2, 2'b00, 2'b10};
    tbl[8]  = '{2'b00, 2'b11, 6'd2, 6'd3, 8'd10, 11, 2'b01, 2'b10};
    tbl[9]  = '{2'b00, 2'b11, 6'd2, 6'd3, 8'd10, 4, 2'b00, 2'b10};
    tbl[10] = '{2'b00, 2'b11, 6'd2, 6'd3, 8'd10, 2, 2'b00, 2'b11};
    // dt_rise 5->1 after the gap started: this gap stays 6, next one is 2
    tbl[11] = '{2'b01, 2'b11, 6'd5, 6'd3, 8'd0,  1, 2'b00, 2'b10};
    tbl[12] = '{2'b01, 2'b11, 6'd1, 6'd3, 8'd0,  5, 2'b00, 2'b10};
    tbl[13] = '{2'b01, 2'b11, 6'd1, 6'd3, 8'd0,  3, 2'b01, 2'b10};
    tbl[14] = '{2'b00, 2'b11, 6'd1, 6'd3, 8'd0,  4, 2'b00, 2'b10};
    tbl[15] = '{2'b00, 2'b11, 6'd1, 6'd3, 8'd0,  1, 2'b00, 2'b11};
    tbl[16] = '{2'b01, 2'b11, 6'd1, 6'd3, 8'd0,  2, 2'b00, 2'b10};
    tbl[17] = '{2'b01, 2'b11, 6'd1, 6'd3, 8'd0,  2, 2'b01, 2'b10};
    // en low clears at once; restart with dt_fall=0 gives a 1-cycle gap
    tbl[18] = '{2'b01, 2'b00, 6'd1, 6'd0, 8'd0,  2, 2'b00, 2'b00};
    tbl[19] = '{2'b01, 2'b11, 6'd1, 6'd0, 8'd0,  1, 2'b00, 2'b00};
    tbl[20] = '{2'b01, 2'b11, 6'd1, 6'd0, 8'd0,  1, 2'b00, 2'b10};
    tbl[21] = '{2'b01, 2'b11, 6'd1, 6'd0, 8'd0,  2, 2'b01, 2'b10};
    // bring both channels to TOP_ON
    tbl[22] = '{2'b11, 2'b11, 6'd1, 6'd0, 8'd0,  2, 2'b01, 2'b00};
    tbl[23] = '{2'b11, 2'b11, 6'd1, 6'd0, 8'd0,  2, 2'b11, 2'b00};

    drive(2'b00, 2'b00, 6'd0, 6'd0, 8'd0);
    bus.fault_n   = 1'b1;
    bus.fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].pwm, tbl[i].en, tbl[i].dt_rise, tbl[i].dt_fall, tbl[i].min_on);
      run($sformatf("vec%0d", i), 1'b0, tbl[i].top, tbl[i].bot, tbl[i].ncyc);
    end

    // fault pulse during TOP_ON: two sync stages, then latched shutdown
    bus.fault_n = 1'b0;
    run("fault_sync1", 1'b0, 2'b11, 2'b00, 1);
    bus.fault_n = 1'b1;
    run("fault_sync2", 1'b0, 2'b11, 2'b00, 1);
    run("fault_forced", 1'b1, 2'b00, 2'b00, 3);
    bus.fault_n = 1'b0;
    run("fault_low_again", 1'b1, 2'b00, 2'b00, 3);
    bus.fault_clr = 1'b1;
    run("clr_ignored", 1'b1, 2'b00, 2'b00, 1);
    bus.fault_clr = 1'b0;
    bus.fault_n   = 1'b1;
    run("fault_held", 1'b1, 2'b00, 2'b00, 3);
    bus.fault_clr = 1'b1;
    run("fault_cleared", 1'b0, 2'b00, 2'b00, 1);
    bus.fault_clr = 1'b0;
    run("restart_dt", 1'b0, 2'b00, 2'b00, 2);
    run("restart_top", 1'b0, 2'b11, 2'b00, 2);

    // async reset while top is high
    rst_n = 1'b0;
    #1;
    check_idle("rst_top_on");
    @(negedge clk);
    rst_n = 1'b1;
    run("rel_a_dt", 1'b0, 2'b00, 2'b00, 2);
    run("rel_a_top", 1'b0, 2'b11, 2'b00, 2);

    // async reset in the middle of a dt_rise=5 gap
    drive(2'b00, 2'b11, 6'd1, 6'd0, 8'd0);
    run("fall_b", 1'b0, 2'b00, 2'b00, 1);
    run("bot_b", 1'b0, 2'b00, 2'b11, 2);
    drive(2'b11, 2'b11, 6'd5, 6'd0, 8'd0);
    run("dt_top_b", 1'b0, 2'b00, 2'b00, 2);
    rst_n = 1'b0;
    #1;
    check_idle("rst_dt_top");
    @(negedge clk);
    rst_n = 1'b1;
    run("rel_b_dt", 1'b0, 2'b00, 2'b00, 6);
    run("rel_b_top", 1'b0, 2'b11, 2'b00, 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
